intersection_phase_scheduler: RTL
=================================

# intersection_phase_scheduler

Actuated phase scheduler for a two-road intersection with an optional pedestrian phase. It shares the single right-of-way among three requesters: road A, road B and pedestrians. It sequences green, yellow, all-red and walk intervals against a 1 Hz tick from the existing clock divider. Its outputs drive the lamp registers and the 7-segment countdown decoder directly.

## Interface
- GREEN_MIN, 3: minimum green length, in ticks.
- GREEN_MAX, 8: maximum green length when a conflicting request is pending.
- YELLOW_T, 2: yellow length, in ticks.
- ALLRED_T, 1: all-red clearance length, in ticks.
- WALK_T, 5: walk length, in ticks.
- clk_in  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- tick  in  1  one-cycle time-base pulse.
- req_a  in  1  road A vehicle detector, level.
- req_b  in  1  road B vehicle detector, level.
- ped_btn  in  1  pedestrian button, pulse or level.
- light_a  out  3  road A lamps, one-hot: 001 red, 010 yellow, 100 green.
- light_b  out  3  road B lamps, same encoding as light_a.
- walk  out  1  pedestrian walk lamp.
- phase  out  2  current state: 0 GREEN, 1 YELLOW, 2 ALLRED, 3 WALK.
- count  out  4  ticks remaining in the current interval, 0..15.

## Operation
- State is the pair (phase, owner), with owner in {A, B, P}. All outputs are registered.
- Reset value of every output:
  - phase = GREEN, owner = A.
  - light_a = 100, light_b = 001, walk = 0, count = GREEN_MIN.
  - Interval timer = 0, ped_pend = 0.
- ped_pend is set by ped_btn on any cycle whose phase is not WALK. It is cleared on entry to WALK and by rst.
- Pending set: the requesters other than the owner. A road is pending while its req is high; P is pending while ped_pend = 1.
- The timer advances only on tick. An interval of length L ends on the tick where timer == L-1; timer then returns to 0.
- GREEN(X), on each tick:
  - Gap-out: timer+1 ≥ GREEN_MIN, req_X = 0 and the pending set is non-empty → YELLOW.
  - Max-out: timer+1 == GREEN_MAX and the pending set is non-empty → YELLOW, regardless of req_X.
  - Otherwise stay in GREEN. The timer saturates at GREEN_MAX-1.
- The next owner is latched on GREEN or WALK exit. It is the first pending requester in the rotation A→B→P→A after the current owner. If nothing is pending at WALK exit, the next owner is A.
- YELLOW(X) lasts YELLOW_T ticks, then ALLRED. ALLRED lasts ALLRED_T ticks, then GREEN(next), or WALK if next = P.
- WALK lasts WALK_T ticks, then ALLRED.
- Lamps:
  - Owner road: green in GREEN, yellow in YELLOW.
  - Every other road: red.
  - ALLRED and WALK: both roads red.
  - walk = 1 only in WALK.
- count:
  - GREEN: GREEN_MIN−timer−1+1 while timer < GREEN_MIN, else 0.
  - Other states: L−timer.
  - Reloaded to the new interval length on every transition.
- tick and rst in the same cycle: rst wins.
- rst mid-interval returns the block to the reset state on the next edge. No yellow or all-red clearance is inserted.

## Timing
- Single clock domain. Every output changes on the clk_in edge that samples tick = 1, or on the rst edge. Latency from sampled tick to output is one cycle.
- req_a, req_b and ped_pend are evaluated in the same cycle as the deciding tick.
- A ped_btn arriving in the same cycle as a GREEN-exit tick does count as pending.
- Between tick pulses, all outputs are stable.

## Configuration
- PED_EN defined:
  - The pedestrian requester, ped_pend and the WALK state are present.
  - The rotation is A→B→P.
- PED_EN undefined:
  - ped_btn is ignored and walk is tied to 0.
  - The rotation is A↔B.
  - phase never takes the value 3.

## Structure
- Shared package holds:
  - The light encodings RED 3'b001, YELLOW 3'b010, GREEN 3'b100.
  - The phase codes and the owner codes.
- One sub-module, phase_rr_pick: combinational. It takes the current owner and the pending vector and returns the next owner plus a valid flag.

## Test plan
Tick k means the k-th tick after reset is released. All cases use default parameters.
- Reset, all requests low, 20 ticks:
  - A stays green; light_a = 100, light_b = 001.
  - count goes 3, 2, 1, then holds at 0 from tick 3.
- req_b = 1, req_a = 0:
  - Gap-out at tick 3: light_a = 010.
  - Tick 5: ALLRED, both roads 001.
  - Tick 6: light_b = 100.
- req_a = 1 and req_b = 1 held:
  - Max-out at tick 8, so A yellow at tick 8.
  - B green at tick 11.
  - B then max-outs 8 ticks later.
- PED_EN, one ped_btn pulse, roads idle:
  - A yellow at tick 3.
  - walk = 1 for ticks 6–10.
  - ALLRED at tick 11.
  - A green at tick 12; ped_pend = 0.
- rst asserted together with a tick during YELLOW: next edge gives the reset values and ped_pend = 0.
- Build without PED_EN, ped_btn pulsed repeatedly: walk stays 0 and A stays green.

Source files
------------

// File: rtl/intersection_phase_scheduler_pkg.sv
// rtl/intersection_phase_scheduler_pkg.sv - lamp encodings, phase/owner codes and lamp helper
package intersection_phase_scheduler_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b100;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2,
    PH_WALK   = 2'd3
  } phase_e;

  // Owner code doubles as the bit index into the pending vector.
  typedef enum logic [1:0] {
    OWN_A = 2'd0,
    OWN_B = 2'd1,
    OWN_P = 2'd2
  } owner_e;

  // A road only shows green/yellow while it owns the right-of-way.
  function automatic logic [2:0] road_lamp(input phase_e ph, input owner_e own, input owner_e road);
    logic [2:0] lamp;
    lamp = LIGHT_RED;
    if (own == road) begin
      if (ph == PH_GREEN) lamp = LIGHT_GREEN;
      else if (ph == PH_YELLOW) lamp = LIGHT_YELLOW;
    end
    return lamp;
  endfunction

endpackage

// File: rtl/intersection_phase_scheduler_pick.sv
// rtl/intersection_phase_scheduler_pick.sv - round-robin next-owner picker (A->B->P->A)
module phase_rr_pick
  import intersection_phase_scheduler_pkg::*;
(
  input  logic [1:0] owner,
  input  logic [2:0] pend,
  output logic [1:0] next_owner,
  output logic       valid
);

  // Search the two requesters following the current owner in rotation order.
  always_comb begin
    next_owner = OWN_A;
    valid      = 1'b0;
    case (owner)
      OWN_A: begin
        if (pend[OWN_B]) begin next_owner = OWN_B; valid = 1'b1; end
        else if (pend[OWN_P]) begin next_owner = OWN_P; valid = 1'b1; end
      end
      OWN_B: begin
        if (pend[OWN_P]) begin next_owner = OWN_P; valid = 1'b1; end
        else if (pend[OWN_A]) begin next_owner = OWN_A; valid = 1'b1; end
      end
      default: begin
        if (pend[OWN_A]) begin next_owner = OWN_A; valid = 1'b1; end
        else if (pend[OWN_B]) begin next_owner = OWN_B; valid = 1'b1; end
      end
    endcase
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// rtl/intersection_phase_scheduler.sv - actuated two-road phase scheduler; PED_EN adds pedestrian walk phase
module intersection_phase_scheduler
  import intersection_phase_scheduler_pkg::*;
#(
  parameter int GREEN_MIN = 3,
  parameter int GREEN_MAX = 8,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 5
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       ped_btn,
  output logic [2:0] light_a,
  output logic [2:0] light_b,
  output logic       walk,
  output logic [1:0] phase,
  output logic [3:0] count
);

  localparam logic [3:0] G_MIN = 4'(GREEN_MIN);
  localparam logic [3:0] G_MAX = 4'(GREEN_MAX);
  localparam logic [3:0] Y_T   = 4'(YELLOW_T);
  localparam logic [3:0] AR_T  = 4'(ALLRED_T);
  localparam logic [3:0] W_T   = 4'(WALK_T);

  phase_e     phase_q, phase_d;
  owner_e     owner_q, owner_d;
  owner_e     next_q, next_d;
  logic [3:0] timer_q, timer_d;
  logic       ped_pend_q, ped_pend_d;
  logic [2:0] light_a_q, light_a_d;
  logic [2:0] light_b_q, light_b_d;
  logic       walk_q, walk_d;
  logic [3:0] count_q, count_d;

  logic       ped_live;
  logic       ped_set;
  logic [2:0] pend;
  logic [1:0] pick_owner;
  logic       pick_valid;
  logic       req_own;
  logic [3:0] timer_inc;

`ifdef PED_EN
  // A button press on the deciding cycle already counts as a pending walk request.
  assign ped_set  = ped_btn && (phase_q != PH_WALK);
  assign ped_live = ped_pend_q | ped_set;
`else
  logic ped_btn_unused;
  assign ped_btn_unused = ped_btn;
  assign ped_set  = 1'b0;
  assign ped_live = ped_pend_q;
`endif

  assign pend      = {ped_live & (owner_q != OWN_P),
                      req_b    & (owner_q != OWN_B),
                      req_a    & (owner_q != OWN_A)};
  assign req_own   = (owner_q == OWN_B) ? req_b : req_a;
  assign timer_inc = timer_q + 4'd1;

  phase_rr_pick u_pick (
    .owner      (owner_q),
    .pend       (pend),
    .next_owner (pick_owner),
    .valid      (pick_valid)
  );

  // Next-state: interval sequencing on tick, pedestrian latch on every cycle, registered lamp/count.
  always_comb begin
    phase_d    = phase_q;
    owner_d    = owner_q;
    next_d     = next_q;
    timer_d    = timer_q;
    ped_pend_d = ped_pend_q | ped_set;
    if (tick) begin
      case (phase_q)
        PH_GREEN: begin
          if (pick_valid && ((timer_inc >= G_MIN && !req_own) || timer_inc == G_MAX)) begin
            phase_d = PH_YELLOW;
            next_d  = owner_e'(pick_owner);
            timer_d = 4'd0;
          end else if (timer_q != G_MAX - 4'd1) begin
            timer_d = timer_inc;
          end
        end
        PH_YELLOW: begin
          if (timer_q == Y_T - 4'd1) begin
            phase_d = PH_ALLRED;
            timer_d = 4'd0;
          end else begin
            timer_d = timer_inc;
          end
        end
        PH_ALLRED: begin
          if (timer_q == AR_T - 4'd1) begin
            owner_d = next_q;
            timer_d = 4'd0;
            if (next_q == OWN_P) begin
              phase_d    = PH_WALK;
              ped_pend_d = 1'b0;
            end else begin
              phase_d = PH_GREEN;
            end
          end else begin
            timer_d = timer_inc;
          end
        end
        default: begin
          if (timer_q == W_T - 4'd1) begin
            phase_d = PH_ALLRED;
            timer_d = 4'd0;
            next_d  = pick_valid ? owner_e'(pick_owner) : OWN_A;
          end else begin
            timer_d = timer_inc;
          end
        end
      endcase
    end

    light_a_d = road_lamp(phase_d, owner_d, OWN_A);
    light_b_d = road_lamp(phase_d, owner_d, OWN_B);
`ifdef PED_EN
    walk_d = (phase_d == PH_WALK);
`else
    walk_d = 1'b0;
`endif
    case (phase_d)
      PH_GREEN:  count_d = (timer_d < G_MIN) ? (G_MIN - timer_d) : 4'd0;
      PH_YELLOW: count_d = Y_T - timer_d;
      PH_ALLRED: count_d = AR_T - timer_d;
      default:   count_d = W_T - timer_d;
    endcase
  end

  // State and output registers; reset puts road A in a fresh green.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      phase_q    <= PH_GREEN;
      owner_q    <= OWN_A;
      next_q     <= OWN_A;
      timer_q    <= 4'd0;
      ped_pend_q <= 1'b0;
      light_a_q  <= LIGHT_GREEN;
      light_b_q  <= LIGHT_RED;
      walk_q     <= 1'b0;
      count_q    <= G_MIN;
    end else begin
      phase_q    <= phase_d;
      owner_q    <= owner_d;
      next_q     <= next_d;
      timer_q    <= timer_d;
      ped_pend_q <= ped_pend_d;
      light_a_q  <= light_a_d;
      light_b_q  <= light_b_d;
      walk_q     <= walk_d;
      count_q    <= count_d;
    end
  end

  assign light_a = light_a_q;
  assign light_b = light_b_q;
  assign walk    = walk_q;
  assign phase   = phase_q;
  assign count   = count_q;

endmodule
